flag_branch_unit: RTL
=====================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; the ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 alu_flags  input  3  ALU flags from EX: [2]=Z, [1]=V, [0]=N.
REQ-005 alu_ctl  input  3  ALU op code of the EX instruction: 000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
REQ-006 alu_valid  input  1  EX holds a valid ALU instruction.
REQ-007 br_valid  input  1  ID holds a conditional branch.
REQ-008 br_cond  input  3  branch condition code.
REQ-009 br_target  input  16  branch target address.
REQ-010 stall  input  1  pipeline stall, freezes the unit.
REQ-011 flush  input  1  external flush that kills the ID instruction.
REQ-012 flags_q  output  3  architectural ZVN register.
REQ-013 br_taken  output  1  one-cycle redirect pulse.
REQ-014 redirect_pc  output  16  registered target, valid while br_taken=1.
REQ-015 flush_if  output  1  kills the fetched wrong-path instruction; equals br_taken.
REQ-016 taken_cnt  output  16  count of taken branches, saturating.

Function
REQ-017 Update mask when alu_valid=1 and stall=0: ADD and SUB write Z, V and N; XOR, SLL, SRA and ROR write Z only; RED and PADDSB write no flags. Bits outside the mask SHALL hold.
REQ-018 Effective flags SHALL be flags_q with the bits written this cycle replaced by alu_flags. This forwards the flag result to a branch in the same cycle.
REQ-019 Conditions on the effective flags:
- 000 NE: !Z
- 001 EQ: Z
- 010 GT: !Z & !N
- 011 LT: N
- 100 GE: Z | !N
- 101 LE: Z | N
- 110 OV: V
- 111 UN: always true
REQ-020 Accept condition: br_valid=1, stall=0, flush=0 and state=RESOLVE.
REQ-021 FSM states are RESOLVE and SHADOW. RESOLVE goes to SHADOW on an accepted branch whose condition is true. SHADOW returns to RESOLVE after one non-stalled cycle.
REQ-022 A taken branch accepted in cycle N SHALL produce br_taken=1, flush_if=1 and redirect_pc=br_target in cycle N+1, each for exactly one cycle.
REQ-023 An accepted branch whose condition is false SHALL produce no pulse and no state change.
REQ-024 In SHADOW, br_valid SHALL be ignored, because that slot holds the wrong-path instruction.
REQ-025 stall=1 SHALL hold the FSM state, flags_q and taken_cnt. br_taken and flush_if SHALL be 0 on the next cycle.
REQ-026 flush=1 SHALL force the state to RESOLVE and block acceptance. Flag updates from EX proceed, because EX holds the older instruction.
REQ-027 taken_cnt SHALL increment on each br_taken pulse and saturate at 16'hFFFF with no wrap.
REQ-028 alu_valid and br_valid in the same cycle SHALL evaluate the branch against the forwarded flags (REQ-018).
REQ-029 redirect_pc SHALL hold its last value while br_taken=0.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) set:
- flags_q=000
- br_taken=0
- flush_if=0
- redirect_pc=16'h0000
- taken_cnt=16'h0000
- state=RESOLVE
REQ-031 Reset during SHADOW or a pending pulse SHALL cancel it. The first accept is possible in the first cycle after release.

Structure
REQ-032 A shared package SHALL hold the ALU op codes, condition codes, flag bit indices (Z=2, V=1, N=0) and the FSM state enum.
REQ-033 The condition evaluation SHALL be a combinational sub-module named branch_cond (inputs: flags and cond; output: taken). All registers stay in flag_branch_unit.

Verification
REQ-034 SUB with alu_flags=111, then XOR with alu_flags=000 -> flags_q=111, then flags_q=011 (Z cleared, V and N held).
REQ-035 ADD with alu_flags=100 in the same cycle as br_valid, cond=001, target=16'h0040 -> next cycle br_taken=1, flush_if=1, redirect_pc=16'h0040; stale flags_q=000 is not used.
REQ-036 Taken UN branch followed immediately by br_valid, cond=111 -> first pulse only; the second branch is ignored in SHADOW and taken_cnt=1.
REQ-037 br_valid, cond=110 with stall=1 for 3 cycles and V=1 -> no pulse during the stall; the branch is accepted when stall drops, and the pulse follows one cycle later.
REQ-038 taken_cnt preset near 16'hFFFE by taken branches, then 3 more taken branches -> value stops at 16'hFFFF.
REQ-039 rst_n asserted mid-cycle during SHADOW -> all outputs reset immediately; a branch in the first cycle after release is accepted.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the flag register / conditional branch resolver.
// ALU op codes, branch condition codes, flag bit positions and FSM states.
package flag_branch_unit_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_RED    = 3'b010,
        ALU_XOR    = 3'b011,
        ALU_SLL    = 3'b100,
        ALU_SRA    = 3'b101,
        ALU_ROR    = 3'b110,
        ALU_PADDSB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_UN = 3'b111
    } cond_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_RESOLVE = 1'b0,
        ST_SHADOW  = 1'b1
    } state_e;

    // Which ZVN bits an ALU op is allowed to write.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        case (op)
            ALU_ADD, ALU_SUB:                   m = 3'b111;
            ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: m = 3'b100;
            default:                            m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_branch_unit_branch_cond.sv
// Combinational branch condition evaluation on a ZVN flag vector.
module branch_cond
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE: taken = !w_z;
            COND_EQ: taken = w_z;
            COND_GT: taken = !w_z && !w_n;
            COND_LT: taken = w_n;
            COND_GE: taken = w_z || !w_n;
            COND_LE: taken = w_z || w_n;
            COND_OV: taken = w_v;
            COND_UN: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural ZVN flag register with EX->ID forwarding and a two-state
// branch resolver that emits a one-cycle redirect and counts taken branches.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  alu_flags,
    input  logic [2:0]  alu_ctl,
    input  logic        alu_valid,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_target,
    input  logic        stall,
    input  logic        flush,
    output logic [2:0]  flags_q,
    output logic        br_taken,
    output logic [15:0] redirect_pc,
    output logic        flush_if,
    output logic [15:0] taken_cnt
);

    logic [2:0]  r_flags;
    logic        r_br_taken;
    logic [15:0] r_redirect_pc;
    logic [15:0] r_taken_cnt;
    state_e      r_state;
    state_e      w_state_nxt;

    logic [2:0]  w_mask;
    logic [2:0]  w_flags_eff;
    logic        w_cond_true;
    logic        w_accept;
    logic        w_take;

    // Bits written this cycle are forwarded so a same-cycle branch sees them.
    assign w_mask      = (alu_valid && !stall) ? flag_mask(alu_ctl) : 3'b000;
    assign w_flags_eff = (r_flags & ~w_mask) | (alu_flags & w_mask);

    branch_cond u_branch_cond (
        .flags (w_flags_eff),
        .cond  (br_cond),
        .taken (w_cond_true)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESOLVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_RESOLVE;
        end else if (!stall) begin
            case (r_state)
                ST_RESOLVE: if (w_take) w_state_nxt = ST_SHADOW;
                ST_SHADOW:  w_state_nxt = ST_RESOLVE;
                default:    w_state_nxt = ST_RESOLVE;
            endcase
        end
    end

    // The slot behind a taken branch is wrong-path, so SHADOW never accepts.
    always_comb begin
        w_accept = br_valid && !stall && !flush && (r_state == ST_RESOLVE);
        w_take   = w_accept && w_cond_true;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= 3'b000;
            r_br_taken    <= 1'b0;
            r_redirect_pc <= 16'h0000;
            r_taken_cnt   <= 16'h0000;
        end else begin
            r_flags    <= w_flags_eff;
            r_br_taken <= w_take;
            if (w_take) begin
                r_redirect_pc <= br_target;
            end
            if (w_take && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
        end
    end

    assign flags_q     = r_flags;
    assign br_taken    = r_br_taken;
    assign flush_if    = r_br_taken;
    assign redirect_pc = r_redirect_pc;
    assign taken_cnt   = r_taken_cnt;

endmodule
